// File: rtl/lat_stim_gen.sv
// Input-lag stimulus: frame-synchronous white box flash with a measurement trigger
// raised at the top of the first lit frame.
module lat_stim_gen #(
  parameter int DARK_FRAMES  = 8,
  parameter int FLASH_FRAMES = 4,
  parameter int BOX_X        = 0,
  parameter int BOX_Y        = 0,
  parameter int BOX_W        = 256,
  parameter int BOX_H        = 256
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        start,
  input  logic        VSYNC_in,
  input  logic [11:0] h_ctr,
  input  logic [10:0] v_ctr,
  input  logic        trig_ack,
  output logic        trigger,
  output logic        patch_on,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DARK  = 2'd1,
    S_FLASH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]  DARK_LAST  = 8'(DARK_FRAMES - 1);
  localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [12:0] X_LO       = 13'(BOX_X);
  localparam logic [12:0] X_LEN      = 13'(BOX_W);
  localparam logic [11:0] Y_LO       = 12'(BOX_Y);
  localparam logic [11:0] Y_LEN      = 12'(BOX_H);

  state_t      r_state;
  state_t      w_state_nx;
  logic [7:0]  r_frame_ctr;
  logic [7:0]  w_ctr_nx;
  logic        r_trigger;
  logic        w_trig_nx;
  logic        r_patch_en;
  logic        w_pen_nx;
  logic        r_vs_l;
  logic        r_patch_on;
  logic        w_fs;
  logic [13:0] w_dx;
  logic [12:0] w_dy;
  logic        w_in_box;

  assign w_fs = r_vs_l & ~VSYNC_in;

  // Offset-from-edge form: the top bit is the borrow, so "below the edge"
  // and "past the far edge" are both a single unsigned test.
  assign w_dx = {2'b00, h_ctr} - {1'b0, X_LO};
  assign w_dy = {2'b00, v_ctr} - {1'b0, Y_LO};
  assign w_in_box = ~w_dx[13] & (w_dx[12:0] < X_LEN)
                  & ~w_dy[12] & (w_dy[11:0] < Y_LEN);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_frame_ctr <= 8'd0;
      r_trigger   <= 1'b0;
      r_patch_en  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_frame_ctr <= w_ctr_nx;
      r_trigger   <= w_trig_nx;
      r_patch_en  <= w_pen_nx;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_vs_l     <= 1'b1;
      r_patch_on <= 1'b0;
    end else begin
      r_vs_l     <= VSYNC_in;
      r_patch_on <= r_patch_en & w_in_box;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ctr_nx   = r_frame_ctr;
    w_trig_nx  = r_trigger;
    w_pen_nx   = r_patch_en;
    unique case (r_state)
      S_IDLE: begin
        w_trig_nx = 1'b0;
        w_pen_nx  = 1'b0;
        if (start & w_fs) begin
          w_state_nx = S_DARK;
          w_ctr_nx   = 8'd0;
        end
      end
      S_DARK: begin
        if (!start) begin
          w_state_nx = S_IDLE;
          w_ctr_nx   = 8'd0;
          w_trig_nx  = 1'b0;
          w_pen_nx   = 1'b0;
        end else if (w_fs) begin
          if (r_frame_ctr == DARK_LAST) begin
            w_state_nx = S_FLASH;
            w_ctr_nx   = 8'd0;
            w_pen_nx   = 1'b1;
            w_trig_nx  = 1'b1;
          end else begin
            w_ctr_nx = r_frame_ctr + 8'd1;
          end
        end
      end
      S_FLASH: begin
        if (!start) begin
          w_state_nx = S_IDLE;
          w_ctr_nx   = 8'd0;
          w_trig_nx  = 1'b0;
          w_pen_nx   = 1'b0;
        end else begin
          if (trig_ack) w_trig_nx = 1'b0;
          if (w_fs) begin
            if (r_frame_ctr == FLASH_LAST) begin
              w_state_nx = S_DONE;
              w_ctr_nx   = 8'd0;
              w_pen_nx   = 1'b0;
              w_trig_nx  = 1'b0;
            end else begin
              w_ctr_nx = r_frame_ctr + 8'd1;
            end
          end
        end
      end
      S_DONE: begin
        if (!start) w_state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy     = (r_state == S_DARK) | (r_state == S_FLASH);
    done     = (r_state == S_DONE);
    trigger  = r_trigger;
    patch_on = r_patch_on;
  end

endmodule

// File: tb/tb_lat_stim_gen.sv
// Directed bench for lat_stim_gen on a 32x10 toy raster
// (vsync low on lines 0..1, box 10..19 x 5..6, DARK=2, FLASH=3).
module tb_lat_stim_gen;

  logic        pclk = 1'b0;
  logic        reset;
  logic        start;
  logic        trig_ack;
  logic [11:0] h_ctr = 12'd0;
  logic [10:0] v_ctr = 11'd3;
  logic        VSYNC_in;
  logic        trigger;
  logic        patch_on;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  lat_stim_gen #(
    .DARK_FRAMES (2),
    .FLASH_FRAMES(3),
    .BOX_X       (10),
    .BOX_Y       (5),
    .BOX_W       (10),
    .BOX_H       (2)
  ) dut (
    .pclk    (pclk),
    .reset   (reset),
    .start   (start),
    .VSYNC_in(VSYNC_in),
    .h_ctr   (h_ctr),
    .v_ctr   (v_ctr),
    .trig_ack(trig_ack),
    .trigger (trigger),
    .patch_on(patch_on),
    .busy    (busy),
    .done    (done)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (h_ctr == 12'd31) begin
      h_ctr <= 12'd0;
      v_ctr <= (v_ctr == 11'd9) ? 11'd0 : v_ctr + 11'd1;
    end else begin
      h_ctr <= h_ctr + 12'd1;
    end
  end

  assign VSYNC_in = (v_ctr >= 11'd2);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_pos(input int v, input int h);
    int n;
    n = 0;
    while (!(int'(v_ctr) == v && int'(h_ctr) == h) && n < 400) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 400) chk("wait_timeout", 0, 1);
  endtask

  // Starts at (0,1), ends at (0,1) of the next frame.
  task automatic frame(output int lit, output logic t0, output logic tl,
                       output logic d0, output logic b0);
    lit = 0;
    t0  = trigger;
    d0  = done;
    b0  = busy;
    tl  = 1'b0;
    for (int i = 0; i < 320; i++) begin
      if (patch_on) lit++;
      if (i == 319) tl = trigger;
      @(negedge pclk);
    end
  endtask

  int   e_lit[7] = '{0, 0, 20, 20, 20, 0, 0};
  logic e_t0[7]  = '{0, 0, 1, 1, 1, 0, 0};
  logic e_tl[7]  = '{0, 0, 1, 1, 1, 0, 0};
  logic e_d0[7]  = '{0, 0, 0, 0, 0, 1, 1};
  logic e_b0[7]  = '{1, 1, 1, 1, 1, 0, 0};

  initial begin
    int   lit;
    logic t0, tl, d0, b0;

    reset    = 1'b1;
    start    = 1'b0;
    trig_ack = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_trigger", trigger, 0);
    chk("rst_patch", patch_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // full sequence, no ack: trigger held through flash
    wait_pos(5, 0);
    start = 1'b1;
    wait_pos(0, 0);
    chk("idle_at_fs", busy, 0);
    @(negedge pclk);
    for (int k = 0; k < 7; k++) begin
      frame(lit, t0, tl, d0, b0);
      chk($sformatf("f%0d_lit", k + 1), lit, e_lit[k]);
      chk($sformatf("f%0d_trig0", k + 1), t0, e_t0[k]);
      chk($sformatf("f%0d_trigl", k + 1), tl, e_tl[k]);
      chk($sformatf("f%0d_done", k + 1), d0, e_d0[k]);
      chk($sformatf("f%0d_busy", k + 1), b0, e_b0[k]);
    end
    start = 1'b0;
    @(negedge pclk);
    chk("exit_done", done, 0);
    chk("exit_busy", busy, 0);

    // trig_ack 100 cycles into flash
    start = 1'b1;
    wait_pos(0, 1);
    frame(lit, t0, tl, d0, b0);
    frame(lit, t0, tl, d0, b0);
    chk("ack_trig_on", trigger, 1);
    repeat (100) @(negedge pclk);
    chk("ack_trig_pre", trigger, 1);
    trig_ack = 1'b1;
    @(negedge pclk);
    chk("ack_trig_fall", trigger, 0);
    trig_ack = 1'b0;
    wait_pos(0, 1);
    frame(lit, t0, tl, d0, b0);
    chk("ack_f2_lit", lit, 20);
    chk("ack_f2_trig", t0 | tl, 0);
    frame(lit, t0, tl, d0, b0);
    chk("ack_f3_lit", lit, 20);
    chk("ack_f3_trig", t0 | tl, 0);
    chk("ack_done", done, 1);

    // abort mid-flash
    start = 1'b0;
    @(negedge pclk);
    chk("ab_pre_done", done, 0);
    start = 1'b1;
    wait_pos(0, 1);
    frame(lit, t0, tl, d0, b0);
    frame(lit, t0, tl, d0, b0);
    wait_pos(5, 15);
    chk("ab_patch_in", patch_on, 1);
    start = 1'b0;
    @(negedge pclk);
    chk("ab_busy", busy, 0);
    chk("ab_trig", trigger, 0);
    chk("ab_done", done, 0);
    chk("ab_patch_lag", patch_on, 1);
    @(negedge pclk);
    chk("ab_patch_off", patch_on, 0);
    start = 1'b1;
    @(negedge pclk);
    chk("ab_wait_fs", busy, 0);
    wait_pos(0, 0);
    chk("ab_wait_fs2", busy, 0);
    @(negedge pclk);
    chk("ab_restart", busy, 1);

    // async reset in DARK
    wait_pos(2, 3);
    #3 reset = 1'b1;
    #1;
    chk("rd_busy", busy, 0);
    chk("rd_trig", trigger, 0);
    chk("rd_patch", patch_on, 0);
    chk("rd_done", done, 0);
    repeat (2) @(negedge pclk);
    #2 reset = 1'b0;
    @(negedge pclk);
    chk("rd_idle", busy, 0);
    wait_pos(0, 0);
    chk("rd_idle_fs", busy, 0);
    @(negedge pclk);
    chk("rd_redark", busy, 1);

    // async reset in FLASH, inside the box
    frame(lit, t0, tl, d0, b0);
    frame(lit, t0, tl, d0, b0);
    wait_pos(5, 12);
    chk("rf_trig_pre", trigger, 1);
    chk("rf_patch_pre", patch_on, 1);
    #2 reset = 1'b1;
    #1;
    chk("rf_trig", trigger, 0);
    chk("rf_patch", patch_on, 0);
    chk("rf_busy", busy, 0);
    repeat (2) @(negedge pclk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
